jtag_sram_bridge: RTL and testbench
===================================

Name: jtag_sram_bridge

Overview:
- Command-frame engine between the virtual-JTAG byte stream and the 64 KiB SRAM, all in the clk domain.
- Parses byte frames (write / read / status) from the JTAG receive path and drives the SRAM address, data and write enable.
- Read data and status bytes go back to the JTAG shifter over a valid/ready stream.
- Replaces the direct jtag-to-sram wiring in top; tck-to-clk byte synchronisation is done upstream.

Parameters:
ADDR_W, 16, SRAM address width
DATA_W, 8, SRAM / stream byte width
TIMEOUT_CYCLES, 1024, max clk cycles allowed between bytes inside a frame before abort

Ports:
clk  in  1  system clock, rising edge
aclr  in  1  reset; synchronous, active-high
rx_data  in  DATA_W  byte from JTAG receive path
rx_valid  in  1  rx_data valid
rx_ready  out  1  bridge accepts rx_data this cycle
tx_data  out  DATA_W  byte to JTAG transmit shifter
tx_valid  out  1  tx_data valid
tx_ready  in  1  shifter accepts tx_data
sram_address  out  ADDR_W  SRAM address
sram_data_out  out  DATA_W  write data to SRAM data_in
sram_data_in  in  DATA_W  read data from SRAM data_out; valid 1 clk after address
sram_write_enable  out  1  one-cycle write strobe
busy  out  1  high whenever state != IDLE
err  out  2  sticky: [0] bad opcode, [1] inter-byte timeout
err_clear  in  1  clears err

Behaviour:
- Reset (aclr high at a clk edge, any state): state=IDLE; rx_ready=1; tx_valid=0, tx_data=0; sram_address=0, sram_data_out=0, sram_write_enable=0; busy=0; err=0; counters=0. Any in-flight frame and pending tx byte are dropped.
- Handshake: a byte transfers on any edge with valid&&ready.
  - tx_data and tx_valid hold stable until accepted.
  - rx_ready is 1 only in IDLE, ADDR_HI, ADDR_LO, LEN and WR_DATA.
- Frame format: OPC, then per opcode:
  - 0xA1 (write): AH, AL, LEN, then N=LEN+1 data bytes (1..256).
  - 0xA2 (read): AH, AL, LEN; the bridge returns N bytes.
  - 0xA3 (status): no further bytes; the bridge returns {6'b0, err}.
- IDLE: on rx byte:
  - 0xA1 or 0xA2 -> ADDR_HI, opcode latched.
  - 0xA3 -> STAT_SEND.
  - other -> set err[0], stay IDLE (byte consumed).
- ADDR_HI -> ADDR_LO -> LEN: each byte is latched into addr[15:8], addr[7:0], remaining=LEN+1 respectively. After LEN: write -> WR_DATA, read -> RD_ISSUE.
- WR_DATA: on rx byte, sram_data_out<=rx_data, sram_address<=addr; next state WR_STROBE.
- WR_STROBE:
  - sram_write_enable=1 for exactly this one cycle.
  - addr<=addr+1 (0xFFFF wraps to 0x0000); remaining-=1.
  - -> IDLE if remaining becomes 0, else WR_DATA.
- RD_ISSUE: sram_address<=addr -> RD_CAPTURE.
- RD_CAPTURE (one-cycle SRAM latency): tx_data<=sram_data_in, tx_valid<=1 -> RD_SEND.
- RD_SEND: on tx handshake, tx_valid<=0, addr+1 (wraps), remaining-=1; -> IDLE if 0 else RD_ISSUE.
- STAT_SEND: tx_data={6'b0,err}, tx_valid=1 until accepted -> IDLE.
- Timing: minimum 2 clk per written byte, 3 clk per read byte.
- Timeout:
  - Applies in ADDR_HI, ADDR_LO, LEN and WR_DATA only.
  - Counter resets on each accepted byte and increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES: set err[1], -> IDLE. No further writes occur; earlier bytes of the frame stay written.
  - Never applies while waiting on tx_ready.
- err_clear zeroes err. When a set and err_clear coincide in the same cycle, the set wins.
- sram_address holds its last value in IDLE.

Test Plan:
- Write frame A1 12 34 02 AA BB CC -> exactly three one-cycle sram_write_enable pulses at 0x1234/0x1235/0x1236 with data AA/BB/CC; busy falls to 0 the cycle after the last strobe.
- Read frame A2 12 34 02 after the above, tx_ready held 1 -> tx bytes AA, BB, CC in order; tx_ready throttled (low 5 cycles per byte) -> same bytes, tx_data stable while tx_valid && !tx_ready.
- Wrap: A1 FF FF 01 11 22 -> writes 0xFFFF=11 and 0x0000=22; read-back A2 FF FF 01 returns 11, 22.
- Errors:
  - Byte 0x55 in IDLE -> err=01, no SRAM activity.
  - A1 00 10 then 1024 idle cycles -> err=11, state IDLE, no write strobe.
  - A3 -> tx byte 0x03.
  - err_clear pulse -> err=0; a second A3 returns 0x00.
- Reset mid-operation: aclr asserted during RD_SEND with tx_ready=0 -> next edge tx_valid=0, busy=0, err=0, rx_ready=1; a new A3 then returns 0x00.
- Max length: A1 00 00 FF + 256 bytes (value=index) -> 256 strobes, 0x0000..0x00FF; reading back A2 00 00 FF yields 0x00..0xFF.

Source files
------------

// File: rtl/jtag_sram_bridge.sv
// rtl/jtag_sram_bridge.sv - command-frame engine between the JTAG byte stream and the SRAM
// Frames: A1 AH AL LEN data.. (write), A2 AH AL LEN (read), A3 (status).
module jtag_sram_bridge #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data_out,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic              sram_write_enable,
    output logic              busy,
    output logic [1:0]        err,
    input  logic              err_clear
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] OPC_WR   = DATA_W'(8'hA1);
    localparam logic [DATA_W-1:0] OPC_RD   = DATA_W'(8'hA2);
    localparam logic [DATA_W-1:0] OPC_STAT = DATA_W'(8'hA3);

    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, LEN, WR_DATA, WR_STROBE,
        RD_ISSUE, RD_CAPTURE, RD_SEND, STAT_SEND
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W:0]   remaining;
    logic              is_write;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [1:0]        err_set;
    logic              rx_fire, tx_fire, tmo_state, tmo_hit, last_byte;

    assign rx_ready = (state == IDLE) || (state == ADDR_HI) || (state == ADDR_LO) ||
                      (state == LEN) || (state == WR_DATA);
    assign busy              = (state != IDLE);
    assign sram_write_enable = (state == WR_STROBE);
    assign rx_fire   = rx_valid && rx_ready;
    assign tx_fire   = tx_valid && tx_ready;
    assign tmo_state = rx_ready && (state != IDLE);
    assign tmo_hit   = tmo_state && !rx_fire && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign last_byte = (remaining == (DATA_W+1)'(1));

    always_comb begin
        next_state = state;
        err_set    = 2'b00;
        unique case (state)
            IDLE: begin
                if (rx_fire) begin
                    if (rx_data == OPC_WR || rx_data == OPC_RD) next_state = ADDR_HI;
                    else if (rx_data == OPC_STAT)              next_state = STAT_SEND;
                    else                                       err_set[0] = 1'b1;
                end
            end
            ADDR_HI:    if (rx_fire) next_state = ADDR_LO;
            ADDR_LO:    if (rx_fire) next_state = LEN;
            LEN:        if (rx_fire) next_state = is_write ? WR_DATA : RD_ISSUE;
            WR_DATA:    if (rx_fire) next_state = WR_STROBE;
            WR_STROBE:  next_state = last_byte ? IDLE : WR_DATA;
            RD_ISSUE:   next_state = RD_CAPTURE;
            RD_CAPTURE: next_state = RD_SEND;
            RD_SEND:    if (tx_fire) next_state = last_byte ? IDLE : RD_ISSUE;
            STAT_SEND:  if (tx_fire) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
        // An abandoned frame drops straight back to IDLE; no further strobes follow.
        if (tmo_hit) begin
            next_state = IDLE;
            err_set[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            is_write      <= 1'b0;
            tmo_cnt       <= '0;
            err           <= 2'b00;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            sram_address  <= '0;
            sram_data_out <= '0;
        end else begin
            state   <= next_state;
            err     <= (err & ~{2{err_clear}}) | err_set;
            tmo_cnt <= (tmo_state && !rx_fire && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        is_write <= (rx_data == OPC_WR);
                        if (rx_data == OPC_STAT) begin
                            tx_data  <= {{(DATA_W-2){1'b0}}, err};
                            tx_valid <= 1'b1;
                        end
                    end
                end
                ADDR_HI:   if (rx_fire) addr <= ADDR_W'({rx_data, addr[DATA_W-1:0]});
                ADDR_LO:   if (rx_fire) addr[DATA_W-1:0] <= rx_data;
                LEN:       if (rx_fire) remaining <= (DATA_W+1)'(rx_data) + 1'b1;
                WR_DATA: begin
                    if (rx_fire) begin
                        sram_data_out <= rx_data;
                        sram_address  <= addr;
                    end
                end
                WR_STROBE: begin
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                RD_ISSUE:  sram_address <= addr;
                RD_CAPTURE: begin
                    tx_data  <= sram_data_in;
                    tx_valid <= 1'b1;
                end
                RD_SEND: begin
                    if (tx_fire) begin
                        tx_valid  <= 1'b0;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                STAT_SEND: if (tx_fire) tx_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_sram_bridge.sv
// tb/tb_jtag_sram_bridge.sv - randomized frame bench for jtag_sram_bridge against a memory-image model
module tb_jtag_sram_bridge;

    logic        clk = 1'b0;
    logic        aclr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] sram_address;
    logic [7:0]  sram_data_out;
    logic [7:0]  sram_data_in;
    logic        sram_write_enable;
    logic        busy;
    logic [1:0]  err;
    logic        err_clear;

    jtag_sram_bridge #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .aclr(aclr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .sram_address(sram_address), .sram_data_out(sram_data_out),
        .sram_data_in(sram_data_in), .sram_write_enable(sram_write_enable),
        .busy(busy), .err(err), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    logic [7:0] sram_mem [0:65535];
    logic [7:0] ref_mem  [0:65535];
    assign sram_data_in = sram_mem[sram_address];
    always @(posedge clk) if (sram_write_enable) sram_mem[sram_address] <= sram_data_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          tx_mode  = 0;
    int          gap_max  = 0;
    logic [1:0]  exp_err;
    logic [23:0] obs_wr[$], exp_wr[$];
    logic [7:0]  obs_tx[$], exp_tx[$];
    logic [7:0]  byte_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sram_write_enable) obs_wr.push_back({sram_address, sram_data_out});
        if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
        if (prev_stall) begin
            chk("tx_hold_valid", tx_valid, 1);
            chk("tx_hold_data", tx_data, prev_data);
        end
        prev_stall = tx_valid && !tx_ready && !aclr;
        prev_data  = tx_data;
    end

    initial begin
        int thr;
        thr = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tx_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (tx_valid && !tx_ready) begin
                        thr++;
                        if (thr >= 5) tx_ready = 1'b1;
                    end else begin
                        tx_ready = 1'b0;
                        thr = 0;
                    end
                end
                default: tx_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, gap_max)) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!rx_ready) chk("rx_ready_wait", rx_ready, 1);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || tx_valid) && n < 5000) begin
            tick();
            n++;
        end
        if (busy) chk("idle_wait", busy, 0);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_wr_count"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
            chk({tag, "_wr"}, obs_wr[i], exp_wr[i]);
        chk({tag, "_tx_count"}, obs_tx.size(), exp_tx.size());
        for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++)
            chk({tag, "_tx"}, obs_tx[i], exp_tx[i]);
        chk({tag, "_err"}, err, exp_err);
        obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete();
    endtask

    task automatic do_write(input logic [15:0] a, input int n);
        logic [15:0] ai;
        send_byte(8'hA1); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(8'(n - 1));
        for (int i = 0; i < n; i++) begin
            ai = a + 16'(i);
            exp_wr.push_back({ai, byte_q[i]});
            ref_mem[ai] = byte_q[i];
            send_byte(byte_q[i]);
        end
        chk("wr_last_strobe", sram_write_enable, 1);
        tick();
        chk("wr_strobe_end", sram_write_enable, 0);
        chk("wr_busy_end", busy, 0);
        compare_all("write");
    endtask

    task automatic do_read(input logic [15:0] a, input int n);
        send_byte(8'hA2); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(8'(n - 1));
        for (int i = 0; i < n; i++) exp_tx.push_back(ref_mem[a + 16'(i)]);
        wait_idle();
        compare_all("read");
    endtask

    task automatic do_status();
        send_byte(8'hA3);
        exp_tx.push_back({6'b0, exp_err});
        wait_idle();
        compare_all("status");
    endtask

    task automatic do_bad(input logic [7:0] b);
        send_byte(b);
        exp_err[0] = 1'b1;
        compare_all("bad_opc");
    endtask

    task automatic do_clear();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_err = 2'b00;
        compare_all("err_clear");
    endtask

    initial begin
        logic [7:0] b;
        int r, n, wt;
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end
        aclr = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; err_clear = 1'b0;
        exp_err = 2'b00;
        repeat (3) tick();
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_addr", sram_address, 0);
        chk("rst_wdata", sram_data_out, 0);
        chk("rst_we", sram_write_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        aclr = 1'b0;
        tick();

        byte_q = '{8'hAA, 8'hBB, 8'hCC};
        do_write(16'h1234, 3);
        do_read(16'h1234, 3);
        tx_mode = 2;
        do_read(16'h1234, 3);
        tx_mode = 0;

        byte_q = '{8'h11, 8'h22};
        do_write(16'hFFFF, 2);
        do_read(16'hFFFF, 2);

        do_bad(8'h55);

        send_byte(8'hA1); send_byte(8'h00); send_byte(8'h10);
        repeat (1023) tick();
        chk("tmo_busy_before", busy, 1);
        tick();
        chk("tmo_busy_after", busy, 0);
        exp_err[1] = 1'b1;
        compare_all("timeout");

        do_status();
        do_clear();
        do_status();

        byte_q.delete();
        for (int i = 0; i < 256; i++) byte_q.push_back(8'(i));
        do_write(16'h0000, 256);
        tx_mode = 1;
        do_read(16'h0000, 256);

        gap_max = 2;
        for (int k = 0; k < 40; k++) begin
            tx_mode = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            n = $urandom_range(1, 16);
            if (r <= 3) begin
                byte_q.delete();
                for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
                do_write(($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                      : 16'($urandom), n);
            end else if (r <= 6) begin
                do_read(16'($urandom), n);
            end else if (r == 7) begin
                do_status();
            end else if (r == 8) begin
                do b = 8'($urandom); while (b == 8'hA1 || b == 8'hA2 || b == 8'hA3);
                do_bad(b);
            end else begin
                do_clear();
            end
        end
        gap_max = 0;

        do_bad(8'h00);
        tx_mode = 3;
        send_byte(8'hA2); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
        wt = 0;
        while (!tx_valid && wt < 100) begin
            tick();
            wt++;
        end
        chk("mid_tx_valid_seen", tx_valid, 1);
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_rx_ready", rx_ready, 1);
        exp_err = 2'b00;
        obs_tx.delete(); exp_tx.delete();
        tx_mode = 0;
        do_status();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
